// File: rtl/alu16_sat_core_if.sv
// ---------------------------------------------------------------------------
// alu16_sat_core_if
// Operand/result bundle for the 16-bit execute-stage ALU.
//   opcode : 4-bit operation select   (master -> slave)
//   in1    : 16-bit operand A         (master -> slave)
//   in2    : 16-bit operand B         (master -> slave)
//   out    : 16-bit combinational result (slave -> master)
//   flags  : registered {Z, V, N}     (slave -> master)
// ---------------------------------------------------------------------------
interface alu16_sat_core_if;
  logic [3:0]  opcode;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [15:0] out;
  logic [2:0]  flags;

  modport master (
    output opcode,
    output in1,
    output in2,
    input  out,
    input  flags
  );

  modport slave (
    input  opcode,
    input  in1,
    input  in2,
    output out,
    output flags
  );
endinterface

// File: rtl/alu16_sat_core.sv
// ---------------------------------------------------------------------------
// alu16_sat_core
// 16-bit integer ALU: two-level carry-lookahead adder (4-bit CLA slices),
// saturating ADD/SUB, XOR, byte reduction, SLL/SRA/ROR and a nibble-parallel
// saturating add. Result is combinational; {Z,V,N} flags are registered.
// Ports:
//   clk   : clock, flags update on rising edge
//   rst_n : synchronous active-low reset, clears flags
//   bus   : alu16_sat_core_if.slave (opcode, in1, in2 -> out, flags)
// ---------------------------------------------------------------------------
module alu16_sat_core (
  input  logic               clk,
  input  logic               rst_n,
  alu16_sat_core_if.slave    bus
);

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;

  // Group propagate/generate of a 4-bit slice: {P, G}. Independent of
  // carry-in, so the second lookahead level can use it directly.
  function automatic logic [1:0] cla4_pg(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] g;
    p = a ^ b;
    g = a & b;
    return {&p,
            g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])};
  endfunction

  // Sum of a 4-bit slice with internal lookahead carries.
  function automatic logic [3:0] cla4_sum(input logic [3:0] a, input logic [3:0] b,
                                          input logic cin);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return p ^ c;
  endfunction

  logic        sub_s;
  logic [15:0] add_b_s;
  logic [3:0]  grp_p_s;
  logic [3:0]  grp_g_s;
  logic [3:0]  grp_c_s;
  logic [15:0] sum_s;
  logic        ovf_s;
  logic [9:0]  red_s;
  logic [3:0]  amt_s;
  logic [15:0] sll_s;
  logic [15:0] sra_s;
  logic [15:0] ror_s;
  logic [15:0] psa_s;
  logic [15:0] result_s;
  logic        sat_s;
  logic        upd_z_s;
  logic        upd_vn_s;
  logic [2:0]  flags_nxt_s;
  logic [2:0]  flags_r;

  // SUB reuses the adder as in1 + ~in2 + 1; every other opcode adds in2 with cin=0.
  assign sub_s   = (bus.opcode == OP_SUB);
  assign add_b_s = sub_s ? ~bus.in2 : bus.in2;

  // Two-level carry lookahead: slice P/G, then group carries, then slice sums.
  always_comb begin
    grp_p_s = 4'b0000;
    grp_g_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      {grp_p_s[i], grp_g_s[i]} = cla4_pg(bus.in1[4*i +: 4], add_b_s[4*i +: 4]);
    end
    grp_c_s[0] = sub_s;
    grp_c_s[1] = grp_g_s[0] | (grp_p_s[0] & sub_s);
    grp_c_s[2] = grp_g_s[1] | (grp_p_s[1] & grp_g_s[0]) | (grp_p_s[1] & grp_p_s[0] & sub_s);
    grp_c_s[3] = grp_g_s[2] | (grp_p_s[2] & grp_g_s[1]) | (grp_p_s[2] & grp_p_s[1] & grp_g_s[0])
               | (grp_p_s[2] & grp_p_s[1] & grp_p_s[0] & sub_s);
    sum_s = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      sum_s[4*i +: 4] = cla4_sum(bus.in1[4*i +: 4], add_b_s[4*i +: 4], grp_c_s[i]);
    end
  end

  // Signed overflow: adder operands agree in sign but the raw sum does not.
  assign ovf_s = (bus.in1[15] == add_b_s[15]) && (sum_s[15] != bus.in1[15]);

  // Byte reduction at 10 bits: four signed bytes cannot exceed +/-512.
  assign red_s = {{2{bus.in1[15]}}, bus.in1[15:8]} + {{2{bus.in1[7]}}, bus.in1[7:0]}
               + {{2{bus.in2[15]}}, bus.in2[15:8]} + {{2{bus.in2[7]}}, bus.in2[7:0]};

  assign amt_s = bus.in2[3:0];
  assign sll_s = bus.in1 << amt_s;
  assign sra_s = $signed(bus.in1) >>> amt_s;
  // Left shift by 16 (amount 0) yields zero, so amount 0 returns in1 unchanged.
  assign ror_s = (bus.in1 >> amt_s) | (bus.in1 << (5'd16 - {1'b0, amt_s}));

  // Nibble-parallel saturating add, no carry between nibbles.
  always_comb begin
    psa_s = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] na;
      logic [3:0] nb;
      logic [3:0] ns;
      na = bus.in1[4*i +: 4];
      nb = bus.in2[4*i +: 4];
      ns = na + nb;
      if ((na[3] == nb[3]) && (ns[3] != na[3])) begin
        psa_s[4*i +: 4] = na[3] ? 4'h8 : 4'h7;
      end else begin
        psa_s[4*i +: 4] = ns;
      end
    end
  end

  // Result select and per-opcode flag enables.
  always_comb begin
    result_s = 16'h0000;
    sat_s    = 1'b0;
    upd_z_s  = 1'b0;
    upd_vn_s = 1'b0;
    case (bus.opcode)
      OP_ADD, OP_SUB: begin
        upd_z_s  = 1'b1;
        upd_vn_s = 1'b1;
        sat_s    = ovf_s;
        if (ovf_s) begin
          result_s = bus.in1[15] ? 16'h8000 : 16'h7FFF;
        end else begin
          result_s = sum_s;
        end
      end
      OP_XOR: begin
        result_s = bus.in1 ^ bus.in2;
        upd_z_s  = 1'b1;
      end
      OP_RED:    result_s = {{6{red_s[9]}}, red_s};
      OP_SLL: begin
        result_s = sll_s;
        upd_z_s  = 1'b1;
      end
      OP_SRA: begin
        result_s = sra_s;
        upd_z_s  = 1'b1;
      end
      OP_ROR: begin
        result_s = ror_s;
        upd_z_s  = 1'b1;
      end
      OP_PADDSB: result_s = psa_s;
      default:   result_s = sum_s;  // 1xxx: wrapping address add
    endcase
  end

  assign bus.out = result_s;

  // Next flag value: enabled bits load, the rest hold.
  always_comb begin
    flags_nxt_s = flags_r;
    if (upd_z_s) begin
      flags_nxt_s[2] = (result_s == 16'h0000);
    end else begin
      flags_nxt_s[2] = flags_r[2];
    end
    if (upd_vn_s) begin
      flags_nxt_s[1] = sat_s;
      flags_nxt_s[0] = result_s[15];
    end else begin
      flags_nxt_s[1] = flags_r[1];
      flags_nxt_s[0] = flags_r[0];
    end
  end

  // Flag register with synchronous reset taking priority over updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_r <= 3'b000;
    end else begin
      flags_r <= flags_nxt_s;
    end
  end

  assign bus.flags = flags_r;

endmodule

// File: tb/tb_alu16_sat_core.sv
// ---------------------------------------------------------------------------
// tb_alu16_sat_core
// Directed test-plan vectors plus randomized vectors, checked against an
// integer-arithmetic reference model of the ALU and its flag register.
// ---------------------------------------------------------------------------
module tb_alu16_sat_core;

  logic clk;
  logic rst_n;
  alu16_sat_core_if bus ();

  alu16_sat_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int   vectors;
  int   miscompares;
  logic [2:0] model_flags;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: result and saturation flag from plain integer arithmetic.
  function automatic logic [15:0] model_out(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b, output logic sat);
    int sa;
    int sb;
    int r;
    int amt;
    logic [15:0] res;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    amt = int'(b[3:0]);
    sat = 1'b0;
    r   = 0;
    res = 16'h0000;
    case (op)
      4'd0, 4'd1: begin
        r = (op == 4'd0) ? sa + sb : sa - sb;
        if (r > 32767) begin
          r = 32767;
          sat = 1'b1;
        end else if (r < -32768) begin
          r = -32768;
          sat = 1'b1;
        end
        res = r[15:0];
      end
      4'd2: res = a ^ b;
      4'd3: begin
        r = int'($signed(a[15:8])) + int'($signed(a[7:0]))
          + int'($signed(b[15:8])) + int'($signed(b[7:0]));
        res = r[15:0];
      end
      4'd4: begin
        r = int'(a) * (1 << amt);
        res = r[15:0];
      end
      4'd5: begin
        r = sa >>> amt;
        res = r[15:0];
      end
      4'd6: begin
        r = (int'(a) >> amt) | (int'(a) << (16 - amt));
        res = r[15:0];
      end
      4'd7: begin
        for (int i = 0; i < 4; i++) begin
          int na;
          int nb;
          int ns;
          na = int'(a[4*i +: 4]);
          nb = int'(b[4*i +: 4]);
          if (na > 7) na = na - 16;
          if (nb > 7) nb = nb - 16;
          ns = na + nb;
          if (ns > 7) ns = 7;
          if (ns < -8) ns = -8;
          res[4*i +: 4] = ns[3:0];
        end
      end
      default: begin
        r = int'(a) + int'(b);
        res = r[15:0];
      end
    endcase
    return res;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive after negedge, check out, clock, check flags.
  task automatic step(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic lit, input logic [15:0] lit_out, input logic [2:0] lit_flags);
    logic [15:0] eo;
    logic        sat;
    @(negedge clk);
    bus.opcode = op;
    bus.in1    = a;
    bus.in2    = b;
    #1;
    eo = model_out(op, a, b, sat);
    chk("out_model", bus.out, eo);
    if (lit) chk("out_plan", bus.out, lit_out);
    if (!rst_n) begin
      model_flags = 3'b000;
    end else if (op == 4'd0 || op == 4'd1) begin
      model_flags = {eo == 16'h0000, sat, eo[15]};
    end else if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) begin
      model_flags[2] = (eo == 16'h0000);
    end
    @(posedge clk);
    #1;
    chk("flags_model", {13'd0, bus.flags}, {13'd0, model_flags});
    if (lit) chk("flags_plan", {13'd0, bus.flags}, {13'd0, lit_flags});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_flags = 3'b000;
    rst_n       = 1'b0;
    bus.opcode  = 4'd0;
    bus.in1     = 16'h0000;
    bus.in2     = 16'h0000;

    // Reset state
    step(4'd0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 3'b000);
    rst_n = 1'b1;

    // Directed test plan
    step(4'd0, 16'h24A3, 16'h0093, 1'b1, 16'h2536, 3'b000);
    step(4'd1, 16'h0032, 16'h0005, 1'b1, 16'h002D, 3'b000);
    step(4'd1, 16'h9000, 16'h9000, 1'b1, 16'h0000, 3'b100);
    step(4'd0, 16'h7F0F, 16'h7888, 1'b1, 16'h7FFF, 3'b010);
    step(4'd0, 16'h9000, 16'h9000, 1'b1, 16'h8000, 3'b011);
    step(4'd1, 16'h0000, 16'h8000, 1'b1, 16'h7FFF, 3'b010);
    step(4'd8, 16'h9000, 16'h9000, 1'b1, 16'h2000, 3'b010);
    step(4'd4, 16'h0001, 16'h0002, 1'b1, 16'h0004, 3'b010);
    step(4'd5, 16'h0008, 16'h0001, 1'b1, 16'h0004, 3'b010);
    step(4'd5, 16'h8000, 16'h000F, 1'b1, 16'hFFFF, 3'b010);
    step(4'd6, 16'h0001, 16'h0002, 1'b1, 16'h4000, 3'b010);
    step(4'd2, 16'h00FF, 16'h00FF, 1'b1, 16'h0000, 3'b110);
    step(4'd7, 16'h10F7, 16'h1087, 1'b1, 16'h2087, 3'b110);
    step(4'd3, 16'h0102, 16'h0304, 1'b1, 16'h000A, 3'b110);
    step(4'd3, 16'h8080, 16'h8080, 1'b1, 16'hFE00, 3'b110);
    step(4'd4, 16'h0003, 16'hFFF0, 1'b1, 16'h0003, 3'b010);
    step(4'd6, 16'hA5C3, 16'h0010, 1'b1, 16'hA5C3, 3'b010);
    step(4'd1, 16'h8000, 16'h0001, 1'b1, 16'h8000, 3'b011);

    // Reset beats an overflowing ADD, then updates resume with the current op
    rst_n = 1'b0;
    step(4'd0, 16'h7F0F, 16'h7888, 1'b1, 16'h7FFF, 3'b000);
    rst_n = 1'b1;
    step(4'd0, 16'h7F0F, 16'h7888, 1'b1, 16'h7FFF, 3'b010);

    // Randomized vectors, biased toward sign-boundary operands
    for (int i = 0; i < 600; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = {a[15], {15{~a[15]}}};
      if ($urandom_range(0, 3) == 0) b = {b[15], 15'd0};
      step(4'($urandom_range(0, 15)), a, b, 1'b0, 16'h0000, 3'b000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
